// File: rtl/memory_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one external memory bus.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for alternating priority on contention; otherwise data always wins.
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_address,
  input  logic        instruction_ready,
  output logic        instruction_wait,
  output logic [31:0] instruction,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_data_store,
  input  logic        memory_read,
  input  logic [1:0]  memory_write,
  input  logic        memory_ready,
  output logic        memory_wait,
  output logic [31:0] memory_data_load,
  output logic        memory_fault,
  output logic        bus_request,
  output logic [31:0] bus_address,
  output logic        bus_write,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_data_out,
  input  logic        bus_ack,
  input  logic [31:0] bus_data_in
);

  typedef enum logic [1:0] {S_IDLE, S_INST, S_DATA} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic       r_inst_done;
  logic       r_data_done;
  logic [7:0] r_count;

  logic w_inst_req;
  logic w_data_req;
  logic w_pick_inst;
  logic w_pick_data;
  logic w_inst_misal;
  logic w_data_misal;
  logic w_data_store;
  logic w_data_noop;

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'd1:    lane_enable = 4'b0001 << addr;
      2'd2:    lane_enable = addr[1] ? 4'b1100 : 4'b0011;
      2'd3:    lane_enable = 4'b1111;
      default: lane_enable = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'd1:    lane_data = {4{data[7:0]}};
      2'd2:    lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

  assign instruction_wait = instruction_ready & ~r_inst_done;
  assign memory_wait      = memory_ready & ~r_data_done;

  // A port that is completing this cycle is not eligible for a new grant.
  assign w_inst_req = instruction_ready & ~r_inst_done;
  assign w_data_req = memory_ready & ~r_data_done;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic r_last_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_data <= 1'b1;
    end else if (r_state == S_IDLE && (w_pick_inst || w_pick_data)) begin
      r_last_data <= w_pick_data;
    end
  end

  assign w_pick_data = w_data_req & ~(w_inst_req & r_last_data);
`else
  assign w_pick_data = w_data_req;
`endif
  assign w_pick_inst = w_inst_req & ~w_pick_data;

  assign w_inst_misal = |instruction_address[1:0];
  assign w_data_store = |memory_write;
  assign w_data_noop  = ~w_data_store & ~memory_read;

  // Loads are checked as word accesses; bytes can never be misaligned.
  always_comb begin
    w_data_misal = 1'b0;
    case (memory_write)
      2'd0:    w_data_misal = memory_read & (|memory_address[1:0]);
      2'd1:    w_data_misal = 1'b0;
      2'd2:    w_data_misal = memory_address[0];
      default: w_data_misal = |memory_address[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_inst_done      <= 1'b0;
      r_data_done      <= 1'b0;
      r_count          <= 8'd0;
      instruction      <= 32'd0;
      memory_data_load <= 32'd0;
      memory_fault     <= 1'b0;
      bus_request      <= 1'b0;
      bus_address      <= 32'd0;
      bus_write        <= 1'b0;
      bus_byte_enable  <= 4'b0000;
      bus_data_out     <= 32'd0;
    end else begin
      r_inst_done <= 1'b0;
      r_data_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_inst) begin
            if (w_inst_misal) begin
              r_inst_done  <= 1'b1;
              instruction  <= 32'd0;
              memory_fault <= 1'b1;
            end else begin
              bus_request     <= 1'b1;
              bus_address     <= {instruction_address[31:2], 2'b00};
              bus_write       <= 1'b0;
              bus_byte_enable <= 4'b0000;
              bus_data_out    <= 32'd0;
              r_count         <= 8'd0;
              r_state         <= S_INST;
            end
          end else if (w_pick_data) begin
            if (w_data_misal) begin
              r_data_done      <= 1'b1;
              memory_data_load <= 32'd0;
              memory_fault     <= 1'b1;
            end else if (w_data_noop) begin
              r_data_done  <= 1'b1;
              memory_fault <= 1'b0;
            end else begin
              bus_request     <= 1'b1;
              bus_address     <= {memory_address[31:2], 2'b00};
              bus_write       <= w_data_store;
              bus_byte_enable <= lane_enable(memory_write, memory_address[1:0]);
              bus_data_out    <= w_data_store ? lane_data(memory_write, memory_data_store) : 32'd0;
              r_count         <= 8'd0;
              r_state         <= S_DATA;
            end
          end
        end
        S_INST, S_DATA: begin
          // An ack in the final allowed cycle still counts as a normal completion.
          if (bus_ack || r_count == LP_LAST) begin
            bus_request  <= 1'b0;
            memory_fault <= ~bus_ack;
            r_state      <= S_IDLE;
            if (r_state == S_INST) begin
              instruction <= bus_ack ? bus_data_in : 32'd0;
              r_inst_done <= 1'b1;
            end else begin
              memory_data_load <= bus_ack ? bus_data_in : 32'd0;
              r_data_done      <= 1'b1;
            end
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: scoreboard of expected completions plus bus-side checks.
// Arbitration expectations follow MEMORY_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] instruction_address;
  logic        instruction_ready;
  logic        instruction_wait;
  logic [31:0] instruction;
  logic [31:0] memory_address;
  logic [31:0] memory_data_store;
  logic        memory_read;
  logic [1:0]  memory_write;
  logic        memory_ready;
  logic        memory_wait;
  logic [31:0] memory_data_load;
  logic        memory_fault;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_data_out;
  logic        bus_ack;
  logic [31:0] rdata;

  logic resp_ack = 1'b0;
  logic force_ack;
  bit   ack_en;
  int   ack_delay;
  int   hi_cnt = 0;

  assign bus_ack = resp_ack | force_ack;

  memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_address (instruction_address),
    .instruction_ready   (instruction_ready),
    .instruction_wait    (instruction_wait),
    .instruction         (instruction),
    .memory_address      (memory_address),
    .memory_data_store   (memory_data_store),
    .memory_read         (memory_read),
    .memory_write        (memory_write),
    .memory_ready        (memory_ready),
    .memory_wait         (memory_wait),
    .memory_data_load    (memory_data_load),
    .memory_fault        (memory_fault),
    .bus_request         (bus_request),
    .bus_address         (bus_address),
    .bus_write           (bus_write),
    .bus_byte_enable     (bus_byte_enable),
    .bus_data_out        (bus_data_out),
    .bus_ack             (bus_ack),
    .bus_data_in         (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks ack_delay cycles after bus_request rises.
  always @(negedge clk) begin
    if (bus_request === 1'b1) begin
      hi_cnt   = hi_cnt + 1;
      resp_ack = ack_en && (hi_cnt == ack_delay + 1);
    end else begin
      hi_cnt   = 0;
      resp_ack = 1'b0;
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          chk;
    bit          fault;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   t0       = 0;
  int   req_hi   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus_request === 1'b1) req_hi++;
  endtask

  task automatic push(input bit port, input logic [31:0] data, input bit chk, input bit fault);
    exp_t e;
    e.port  = port;
    e.data  = data;
    e.chk   = chk;
    e.fault = fault;
    q.push_back(e);
  endtask

  task automatic issue_fetch(input logic [31:0] addr);
    step();
    instruction_address = addr;
    instruction_ready   = 1'b1;
    t0     = cyc;
    req_hi = 0;
  endtask

  task automatic issue_mem(input logic [31:0] addr, input logic [31:0] data,
                           input logic rd, input logic [1:0] wr);
    step();
    memory_address    = addr;
    memory_data_store = data;
    memory_read       = rd;
    memory_write      = wr;
    memory_ready      = 1'b1;
    t0     = cyc;
    req_hi = 0;
  endtask

  task automatic wait_done(input string tag, input bit keep);
    bit   found;
    bit   port;
    exp_t e;
    found = 1'b0;
    port  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instruction_ready && !instruction_wait) begin
        found = 1'b1;
        port  = 1'b0;
      end else if (memory_ready && !memory_wait) begin
        found = 1'b1;
        port  = 1'b1;
      end
    end
    check({tag, " completion seen"}, 32'(found), 32'd1);
    if (found) begin
      check({tag, " scoreboard entry"}, 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({tag, " port"}, 32'(port), 32'(e.port));
        if (e.chk) check({tag, " data"}, port ? memory_data_load : instruction, e.data);
        check({tag, " fault"}, 32'(memory_fault), 32'(e.fault));
      end
      if (!keep) begin
        if (port) memory_ready = 1'b0;
        else instruction_ready = 1'b0;
      end
    end
  endtask

  logic [31:0] st_addr [5] = '{32'h102, 32'h103, 32'h206, 32'h200, 32'h30C};
  logic [31:0] st_data [5] = '{32'h123456A5, 32'h0000003C, 32'hFFFFBEEF, 32'h00001234, 32'hDEADBEEF};
  logic [1:0]  st_wr   [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
  logic        st_rd   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] st_ba   [5] = '{32'h100, 32'h100, 32'h204, 32'h200, 32'h30C};
  logic [3:0]  st_be   [5] = '{4'b0100, 4'b1000, 4'b1100, 4'b0011, 4'b1111};
  logic [31:0] st_do   [5] = '{32'hA5A5A5A5, 32'h3C3C3C3C, 32'hBEEFBEEF, 32'h12341234, 32'hDEADBEEF};

  bit          ma_port [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] ma_addr [4] = '{32'h12, 32'h203, 32'h301, 32'h42};
  logic [1:0]  ma_wr   [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
  logic        ma_rd   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    instruction_address = 32'd0;
    instruction_ready   = 1'b0;
    memory_address      = 32'd0;
    memory_data_store   = 32'd0;
    memory_read         = 1'b0;
    memory_write        = 2'd0;
    memory_ready        = 1'b0;
    force_ack           = 1'b0;
    ack_en              = 1'b1;
    ack_delay           = 1;
    rdata               = 32'd0;
    step();
    step();
    check("reset bus_request", 32'(bus_request), 32'd0);
    check("reset bus_address", bus_address, 32'd0);
    check("reset bus_byte_enable", 32'(bus_byte_enable), 32'd0);
    check("reset instruction", instruction, 32'd0);
    check("reset memory_fault", 32'(memory_fault), 32'd0);
    check("reset waits", 32'({instruction_wait, memory_wait}), 32'd0);
    rst = 1'b1;

    // Aligned fetch acked 3 cycles after bus_request rises
    rdata = 32'h13;
    ack_delay = 3;
    issue_fetch(32'h10);
    push(1'b0, 32'h13, 1'b1, 1'b0);
    step();
    check("fetch bus_request", 32'(bus_request), 32'd1);
    check("fetch bus_address", bus_address, 32'h10);
    check("fetch bus_write", 32'(bus_write), 32'd0);
    check("fetch bus_byte_enable", 32'(bus_byte_enable), 32'd0);
    wait_done("fetch", 1'b0);
    check("fetch latency", cyc - t0, 32'd5);
    check("fetch request cycles", req_hi, 32'd4);

    // Store lane replication and strobes
    ack_delay = 1;
    rdata = 32'hFFFF0000;
    for (int i = 0; i < 5; i++) begin
      issue_mem(st_addr[i], st_data[i], st_rd[i], st_wr[i]);
      push(1'b1, 32'd0, 1'b0, 1'b0);
      step();
      check("store bus_request", 32'(bus_request), 32'd1);
      check("store bus_address", bus_address, st_ba[i]);
      check("store bus_write", 32'(bus_write), 32'd1);
      check("store bus_byte_enable", 32'(bus_byte_enable), 32'(st_be[i]));
      check("store bus_data_out", bus_data_out, st_do[i]);
      wait_done("store", 1'b0);
      check("store latency", cyc - t0, 32'd3);
    end

    // Aligned load
    rdata = 32'hCAFEF00D;
    ack_delay = 2;
    issue_mem(32'h40, 32'h0, 1'b1, 2'd0);
    push(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    step();
    check("load bus_address", bus_address, 32'h40);
    check("load bus_write", 32'(bus_write), 32'd0);
    check("load bus_byte_enable", 32'(bus_byte_enable), 32'd0);
    wait_done("load", 1'b0);
    check("load latency", cyc - t0, 32'd4);

    // No-op data request keeps the previous load word
    issue_mem(32'h50, 32'h0, 1'b0, 2'd0);
    push(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    wait_done("noop", 1'b0);
    check("noop latency", cyc - t0, 32'd1);
    check("noop no bus", req_hi, 32'd0);
    check("instruction held", instruction, 32'h13);

    // Timeout with no ack
    ack_en = 1'b0;
    issue_mem(32'h80, 32'h0, 1'b1, 2'd0);
    push(1'b1, 32'd0, 1'b1, 1'b1);
    wait_done("timeout", 1'b0);
    check("timeout latency", cyc - t0, 32'd5);
    check("timeout request cycles", req_hi, 32'd4);
    ack_en = 1'b1;

    // Misaligned accesses: no bus transaction, faulted completion in cycle 1
    for (int i = 0; i < 4; i++) begin
      if (ma_port[i]) issue_mem(ma_addr[i], 32'hFFFF, ma_rd[i], ma_wr[i]);
      else issue_fetch(ma_addr[i]);
      push(ma_port[i], 32'd0, 1'b1, 1'b1);
      wait_done("misaligned", 1'b0);
      check("misaligned latency", cyc - t0, 32'd1);
      check("misaligned no bus", req_hi, 32'd0);
    end

    // Leave non-zero state ahead of the mid-transaction reset
    ack_delay = 1;
    rdata = 32'h12345678;
    issue_mem(32'h60, 32'h0, 1'b1, 2'd0);
    push(1'b1, 32'h12345678, 1'b1, 1'b0);
    wait_done("preload", 1'b0);
    issue_fetch(32'h12);
    push(1'b0, 32'd0, 1'b1, 1'b1);
    wait_done("prefault", 1'b0);

    // Reset in the second cycle of a DATA transaction, late ack afterwards
    ack_en = 1'b0;
    issue_mem(32'h70, 32'h0, 1'b1, 2'd0);
    step();
    check("abort bus_request", 32'(bus_request), 32'd1);
    step();
    rst = 1'b0;
    memory_ready = 1'b0;
    step();
    check("abort bus_request cleared", 32'(bus_request), 32'd0);
    check("abort bus_address cleared", bus_address, 32'd0);
    check("abort load cleared", memory_data_load, 32'd0);
    check("abort fault cleared", 32'(memory_fault), 32'd0);
    rst = 1'b1;
    rdata = 32'hBAD0BAD0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("late ack bus_request", 32'(bus_request), 32'd0);
    check("late ack load", memory_data_load, 32'd0);
    check("late ack fault", 32'(memory_fault), 32'd0);
    ack_en = 1'b1;
    rdata = 32'h600D;
    issue_fetch(32'h44);
    push(1'b0, 32'h600D, 1'b1, 1'b0);
    step();
    check("post-reset bus_address", bus_address, 32'h44);
    wait_done("post-reset fetch", 1'b0);
    check("post-reset latency", cyc - t0, 32'd3);

    // Contention from reset with both requests held
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    rdata = 32'h11112222;
    instruction_address = 32'h100;
    memory_address = 32'h200;
    memory_read = 1'b1;
    memory_write = 2'd0;
    instruction_ready = 1'b1;
    memory_ready = 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    push(1'b0, 32'h11112222, 1'b1, 1'b0);
    push(1'b1, 32'h11112222, 1'b1, 1'b0);
    push(1'b0, 32'h11112222, 1'b1, 1'b0);
`else
    push(1'b1, 32'h11112222, 1'b1, 1'b0);
    push(1'b0, 32'h11112222, 1'b1, 1'b0);
    push(1'b1, 32'h11112222, 1'b1, 1'b0);
`endif
    wait_done("contend 1st", 1'b1);
    wait_done("contend 2nd", 1'b0);
    wait_done("contend 3rd", 1'b0);

    // Contention right after a lone data grant
    issue_mem(32'h210, 32'h0, 1'b1, 2'd0);
    push(1'b1, 32'h11112222, 1'b1, 1'b0);
    wait_done("lone data", 1'b0);
    step();
    instruction_address = 32'h104;
    memory_address = 32'h214;
    instruction_ready = 1'b1;
    memory_ready = 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    push(1'b0, 32'h11112222, 1'b1, 1'b0);
    push(1'b1, 32'h11112222, 1'b1, 1'b0);
`else
    push(1'b1, 32'h11112222, 1'b1, 1'b0);
    push(1'b0, 32'h11112222, 1'b1, 1'b0);
`endif
    wait_done("after data 1st", 1'b0);
    wait_done("after data 2nd", 1'b0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
